// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order reservation stations: operand source slots and RS entries.
package ooo_pkg;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 8;

    // disp_flags bit marking source 1 as an unused immediate slot
    localparam int FLAG_SRC1_IMM = 1;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] operand;
        rs_src_t [1:0]     src;
        logic [7:0]        wbs;
        logic [7:0]        flags;
        logic [TAG_W-1:0]  robid;
    } rs_entry_t;
endpackage

// File: rtl/rs_pick_oldest.sv
// Age-matrix bookkeeping for the RS slots and one-hot selection of the oldest ready slot.
module rs_pick_oldest #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] free_oh,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant
);
    // older_q[i][j] = 1 : slot i was allocated before slot j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [DEPTH-1:0] col;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) older_d[i] = older_q[i];
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (flush || free_oh[i] || free_oh[j]) older_d[i][j] = 1'b0;
                else if (alloc_oh[j])                  older_d[i][j] = valid[i];
                else if (alloc_oh[i])                  older_d[i][j] = 1'b0;
            end
        end
    end

    always_comb begin
        grant = '0;
        col   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) col[j] = older_q[j][i];
            grant[i] = ready[i] & ~|(ready & col);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
        end
    end
endmodule

// File: rtl/sel_rs.sv
// Reservation station for the select FU: holds ops until both sources are valid (CDB snoop),
// then issues the oldest ready op as a one-cycle transmit pulse when the FU is free.
module sel_rs #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [DATA_W-1:0]   disp_operand,
    input  logic [1:0]          disp_dep_rdy,
    input  logic [2*TAG_W-1:0]  disp_dep_tag,
    input  logic [2*DATA_W-1:0] disp_dep_val,
    input  logic [7:0]          disp_wbs,
    input  logic [7:0]          disp_flags,
    input  logic [TAG_W-1:0]    disp_robid,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_id,
    input  logic [DATA_W-1:0]   cdb_val,
    input  logic                fu_busy,
    output logic                issue_transmit,
    output logic [DATA_W-1:0]   issue_operand,
    output logic [2*DATA_W-1:0] issue_depvals,
    output logic [7:0]          issue_wbs,
    output logic [7:0]          issue_flags,
    output logic [TAG_W-1:0]    issue_robid
);
    import ooo_pkg::*;

    rs_entry_t entries_q [DEPTH];
    rs_entry_t entries_d [DEPTH];
    rs_entry_t new_entry;

    logic [DEPTH-1:0] valid_vec, ready_vec, free_slot_oh, alloc_oh, free_oh, grant;
    logic             alloc_en, issue_en, slot_found;

    logic                issue_transmit_q, issue_transmit_d;
    logic [DATA_W-1:0]   issue_operand_q, issue_operand_d, sel_operand;
    logic [2*DATA_W-1:0] issue_depvals_q, issue_depvals_d, sel_depvals;
    logic [7:0]          issue_wbs_q, issue_wbs_d, sel_wbs;
    logic [7:0]          issue_flags_q, issue_flags_d, sel_flags;
    logic [TAG_W-1:0]    issue_robid_q, issue_robid_d, sel_robid;

    always_comb begin
        valid_vec    = '0;
        ready_vec    = '0;
        free_slot_oh = '0;
        slot_found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            ready_vec[i] = entries_q[i].valid & entries_q[i].src[0].rdy & entries_q[i].src[1].rdy;
            if (!entries_q[i].valid && !slot_found) begin
                free_slot_oh[i] = 1'b1;
                slot_found      = 1'b1;
            end
        end
    end

    assign disp_ready = ~&valid_vec;
    assign alloc_en   = disp_valid & disp_ready & ~flush;
    assign alloc_oh   = alloc_en ? free_slot_oh : '0;
    assign issue_en   = ~fu_busy & ~flush & (|grant);
    assign free_oh    = issue_en ? grant : '0;

    rs_pick_oldest #(.DEPTH(DEPTH)) u_pick (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .valid    (valid_vec),
        .alloc_oh (alloc_oh),
        .free_oh  (free_oh),
        .ready    (ready_vec),
        .grant    (grant)
    );

    // Dispatch payload, including same-cycle CDB bypass for sources not yet ready
    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.operand = disp_operand;
        new_entry.wbs     = disp_wbs;
        new_entry.flags   = disp_flags;
        new_entry.robid   = disp_robid;
        for (int k = 0; k < 2; k++) begin
            new_entry.src[k].tag = disp_dep_tag[k*TAG_W +: TAG_W];
            if (disp_dep_rdy[k]) begin
                new_entry.src[k].rdy = 1'b1;
                new_entry.src[k].val = disp_dep_val[k*DATA_W +: DATA_W];
            end else if (cdb_valid && cdb_id == disp_dep_tag[k*TAG_W +: TAG_W]) begin
                new_entry.src[k].rdy = 1'b1;
                new_entry.src[k].val = cdb_val;
            end
        end
        if (disp_flags[FLAG_SRC1_IMM]) begin
            new_entry.src[1].rdy = 1'b1;
            new_entry.src[1].val = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (flush) begin
                entries_d[i].valid = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (entries_q[i].valid && !entries_q[i].src[k].rdy && cdb_valid &&
                        entries_q[i].src[k].tag == cdb_id) begin
                        entries_d[i].src[k].rdy = 1'b1;
                        entries_d[i].src[k].val = cdb_val;
                    end
                end
                if (free_oh[i])  entries_d[i].valid = 1'b0;
                if (alloc_oh[i]) entries_d[i] = new_entry;
            end
        end
    end

    // Grant is one-hot, so an OR across slots acts as the payload mux
    always_comb begin
        sel_operand = '0;
        sel_depvals = '0;
        sel_wbs     = '0;
        sel_flags   = '0;
        sel_robid   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_operand = sel_operand | entries_q[i].operand;
                sel_depvals = sel_depvals | {entries_q[i].src[1].val, entries_q[i].src[0].val};
                sel_wbs     = sel_wbs     | entries_q[i].wbs;
                sel_flags   = sel_flags   | entries_q[i].flags;
                sel_robid   = sel_robid   | entries_q[i].robid;
            end
        end
    end

    always_comb begin
        issue_transmit_d = issue_en;
        issue_operand_d  = issue_operand_q;
        issue_depvals_d  = issue_depvals_q;
        issue_wbs_d      = issue_wbs_q;
        issue_flags_d    = issue_flags_q;
        issue_robid_d    = issue_robid_q;
        if (issue_en) begin
            issue_operand_d = sel_operand;
            issue_depvals_d = sel_depvals;
            issue_wbs_d     = sel_wbs;
            issue_flags_d   = sel_flags;
            issue_robid_d   = sel_robid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            issue_transmit_q <= 1'b0;
            issue_operand_q  <= '0;
            issue_depvals_q  <= '0;
            issue_wbs_q      <= '0;
            issue_flags_q    <= '0;
            issue_robid_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
            issue_transmit_q <= issue_transmit_d;
            issue_operand_q  <= issue_operand_d;
            issue_depvals_q  <= issue_depvals_d;
            issue_wbs_q      <= issue_wbs_d;
            issue_flags_q    <= issue_flags_d;
            issue_robid_q    <= issue_robid_d;
        end
    end

    assign issue_transmit = issue_transmit_q;
    assign issue_operand  = issue_operand_q;
    assign issue_depvals  = issue_depvals_q;
    assign issue_wbs      = issue_wbs_q;
    assign issue_flags    = issue_flags_q;
    assign issue_robid    = issue_robid_q;
endmodule

// File: tb/tb_sel_rs.sv
// Bench for sel_rs: directed scenarios plus random traffic against an age-ordered queue model.
module tb_sel_rs;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush = 1'b0;
    logic                disp_valid = 1'b0;
    logic                disp_ready;
    logic [DATA_W-1:0]   disp_operand = '0;
    logic [1:0]          disp_dep_rdy = '0;
    logic [2*TAG_W-1:0]  disp_dep_tag = '0;
    logic [2*DATA_W-1:0] disp_dep_val = '0;
    logic [7:0]          disp_wbs = '0;
    logic [7:0]          disp_flags = '0;
    logic [TAG_W-1:0]    disp_robid = '0;
    logic                cdb_valid = 1'b0;
    logic [TAG_W-1:0]    cdb_id = '0;
    logic [DATA_W-1:0]   cdb_val = '0;
    logic                fu_busy = 1'b0;
    logic                issue_transmit;
    logic [DATA_W-1:0]   issue_operand;
    logic [2*DATA_W-1:0] issue_depvals;
    logic [7:0]          issue_wbs;
    logic [7:0]          issue_flags;
    logic [TAG_W-1:0]    issue_robid;

    always #5 clk = ~clk;

    sel_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_operand(disp_operand),
        .disp_dep_rdy(disp_dep_rdy), .disp_dep_tag(disp_dep_tag), .disp_dep_val(disp_dep_val),
        .disp_wbs(disp_wbs), .disp_flags(disp_flags), .disp_robid(disp_robid),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .fu_busy(fu_busy),
        .issue_transmit(issue_transmit), .issue_operand(issue_operand),
        .issue_depvals(issue_depvals), .issue_wbs(issue_wbs), .issue_flags(issue_flags),
        .issue_robid(issue_robid)
    );

    typedef struct packed {
        logic [DATA_W-1:0]      operand;
        logic [1:0]             rdy;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0][DATA_W-1:0] val;
        logic [7:0]             wbs;
        logic [7:0]             flags;
        logic [TAG_W-1:0]       robid;
    } op_t;

    // Model: ops kept in dispatch order, so the first ready one is the oldest
    op_t                 mq[$];
    logic                exp_tx;
    logic [DATA_W-1:0]   exp_operand;
    logic [2*DATA_W-1:0] exp_depvals;
    logic [7:0]          exp_wbs, exp_flags;
    logic [TAG_W-1:0]    exp_robid;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_tx = 0; exp_operand = '0; exp_depvals = '0;
        exp_wbs = '0; exp_flags = '0; exp_robid = '0;
    endtask

    task automatic model_edge();
        int  pick;
        bit  had_room;
        op_t o;
        if (!rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            mq.delete();
            exp_tx = 0;
            return;
        end
        had_room = (mq.size() < DEPTH);
        pick = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].rdy == 2'b11) begin pick = i; break; end
        exp_tx = 0;
        if (!fu_busy && pick >= 0) begin
            exp_tx      = 1;
            exp_operand = mq[pick].operand;
            exp_depvals = mq[pick].val;
            exp_wbs     = mq[pick].wbs;
            exp_flags   = mq[pick].flags;
            exp_robid   = mq[pick].robid;
            mq.delete(pick);
        end
        if (cdb_valid)
            for (int i = 0; i < mq.size(); i++)
                for (int k = 0; k < 2; k++)
                    if (!mq[i].rdy[k] && mq[i].tag[k] == cdb_id) begin
                        mq[i].rdy[k] = 1'b1;
                        mq[i].val[k] = cdb_val;
                    end
        if (disp_valid && had_room) begin
            o = '0;
            o.operand = disp_operand; o.wbs = disp_wbs;
            o.flags = disp_flags; o.robid = disp_robid;
            for (int k = 0; k < 2; k++) begin
                o.tag[k] = disp_dep_tag[k*TAG_W +: TAG_W];
                if (disp_dep_rdy[k]) begin
                    o.rdy[k] = 1'b1; o.val[k] = disp_dep_val[k*DATA_W +: DATA_W];
                end else if (cdb_valid && cdb_id == o.tag[k]) begin
                    o.rdy[k] = 1'b1; o.val[k] = cdb_val;
                end
            end
            if (disp_flags[1]) begin o.rdy[1] = 1'b1; o.val[1] = '0; end
            mq.push_back(o);
        end
    endtask

    task automatic check_outputs(input string t);
        check_val({t, "_tx"}, issue_transmit, exp_tx);
        check_val({t, "_disp_ready"}, disp_ready, mq.size() < DEPTH);
        check_val({t, "_operand"}, issue_operand, exp_operand);
        check_val({t, "_depvals"}, issue_depvals, exp_depvals);
        check_val({t, "_wbs"}, issue_wbs, exp_wbs);
        check_val({t, "_flags"}, issue_flags, exp_flags);
        check_val({t, "_robid"}, issue_robid, exp_robid);
    endtask

    task automatic cyc(input string t);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(t);
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; cdb_valid = 0; fu_busy = 0;
    endtask

    task automatic set_disp(input logic [1:0] rdy, input logic [7:0] tags,
                            input logic [15:0] vals, input logic [3:0] robid);
        disp_valid = 1; disp_dep_rdy = rdy; disp_dep_tag = tags; disp_dep_val = vals;
        disp_robid = robid; disp_operand = 8'h40 + 8'(robid);
        disp_wbs = 8'h10 + 8'(robid); disp_flags = 8'h00;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs("reset");
        #12 rst = 1;
        cyc("post_reset");

        // Ready dispatch: issue one edge after the dispatch edge
        set_disp(2'b11, 8'h00, 16'h2211, 4'd3);
        cyc("t2_disp");
        check_val("t2_no_early_tx", issue_transmit, 1'b0);
        idle();
        cyc("t2_issue");
        check_val("t2_tx", issue_transmit, 1'b1);
        check_val("t2_depvals", issue_depvals, 16'h2211);
        check_val("t2_robid", issue_robid, 4'd3);
        cyc("t2_after");
        check_val("t2_one_pulse", issue_transmit, 1'b0);

        // Wakeup via CDB, then dispatch-time bypass
        set_disp(2'b10, 8'h05, 16'h3300, 4'd6);
        cyc("t3_disp");
        idle();
        cdb_valid = 1; cdb_id = 4'd5; cdb_val = 8'hA5;
        cyc("t3_wake");
        check_val("t3_no_same_cycle", issue_transmit, 1'b0);
        idle();
        cyc("t3_issue");
        check_val("t3_tx", issue_transmit, 1'b1);
        check_val("t3_src0", issue_depvals[7:0], 8'hA5);
        set_disp(2'b10, 8'h05, 16'h3300, 4'd7);
        cdb_valid = 1; cdb_id = 4'd5; cdb_val = 8'hA5;
        cyc("t3_bypass_disp");
        idle();
        cyc("t3_bypass_issue");
        check_val("t3_bypass_tx", issue_transmit, 1'b1);
        check_val("t3_bypass_src0", issue_depvals[7:0], 8'hA5);

        // Full and age order, with FU stall
        fu_busy = 1;
        for (int r = 1; r <= 4; r++) begin
            set_disp(2'b11, 8'h00, 16'h0100 + 16'(r), 4'(r));
            cyc("t4_fill");
            check_val("t4_stall_tx", issue_transmit, 1'b0);
        end
        check_val("t4_full", disp_ready, 1'b0);
        set_disp(2'b11, 8'h00, 16'h0909, 4'd9);
        cyc("t4_drop");
        idle();
        for (int r = 1; r <= 4; r++) begin
            cyc("t4_drain");
            check_val("t4_tx", issue_transmit, 1'b1);
            check_val("t4_order", issue_robid, 4'(r));
        end
        cyc("t4_empty");
        check_val("t4_done", issue_transmit, 1'b0);

        // Flush with simultaneous dispatch
        fu_busy = 1;
        for (int r = 1; r <= 3; r++) begin
            set_disp(2'b11, 8'h00, 16'h0505, 4'(r + 10));
            cyc("t6_fill");
        end
        flush = 1; disp_valid = 1;
        cyc("t6_flush");
        check_val("t6_tx", issue_transmit, 1'b0);
        check_val("t6_ready", disp_ready, 1'b1);
        idle();
        for (int c = 0; c < 3; c++) begin
            cyc("t6_after");
            check_val("t6_no_issue", issue_transmit, 1'b0);
        end

        // Asynchronous reset mid-run with queued ops
        fu_busy = 1;
        for (int r = 1; r <= 2; r++) begin
            set_disp(2'b11, 8'h00, 16'h0707, 4'(r));
            cyc("t1_fill");
        end
        idle();
        fu_busy = 1;
        #2 rst = 0;
        model_reset();
        #1;
        check_val("t1_tx", issue_transmit, 1'b0);
        check_val("t1_ready", disp_ready, 1'b1);
        check_outputs("t1_reset");
        cyc("t1_hold");
        rst = 1; fu_busy = 0;
        for (int c = 0; c < 3; c++) begin
            cyc("t1_after");
            check_val("t1_no_issue", issue_transmit, 1'b0);
        end

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            disp_valid   = ($urandom_range(0, 9) < 6);
            disp_operand = 8'($urandom);
            disp_dep_rdy = 2'($urandom);
            disp_dep_tag = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            disp_dep_val = 16'($urandom);
            disp_wbs     = 8'($urandom);
            disp_flags   = 8'($urandom);
            disp_robid   = 4'($urandom);
            cdb_valid    = $urandom_range(0, 1) == 1;
            cdb_id       = 4'($urandom_range(0, 7));
            cdb_val      = 8'($urandom);
            fu_busy      = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 63) == 0);
            cyc("rand");
        end
        idle();
        cyc("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
